// File: rtl/mult_operand_sequencer_pkg.sv
// Shared types and constants for the multiplier operand sequencer slice.
package mult_pkg;

  // Default operand width of the team shift-add multiplier.
  localparam int MULT_N = 8;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/mult_operand_sequencer_if.sv
// Bundle of the producer, multiplier and consumer handshakes of the sequencer.
// master = sequencer side, slave = surrounding environment.
interface mult_operand_sequencer_if
  import mult_pkg::*;
#(
  parameter int N     = MULT_N,
  parameter int DEPTH = 4
);

  logic                       in_valid;
  logic                       in_ready;
  logic [N-1:0]               in_a;
  logic [N-1:0]               in_b;
  logic                       mul_start;
  logic [N-1:0]               mul_multiplicand;
  logic [N-1:0]               mul_multiplier;
  logic [2*N-1:0]             mul_product;
  logic                       mul_done;
  logic                       out_valid;
  logic                       out_ready;
  logic [2*N-1:0]             out_product;
  logic                       out_err;
  logic [$clog2(DEPTH):0]     fifo_level;

  modport master (
    input  in_valid, in_a, in_b, mul_product, mul_done, out_ready,
    output in_ready, mul_start, mul_multiplicand, mul_multiplier,
           out_valid, out_product, out_err, fifo_level
  );

  modport slave (
    output in_valid, in_a, in_b, mul_product, mul_done, out_ready,
    input  in_ready, mul_start, mul_multiplicand, mul_multiplier,
           out_valid, out_product, out_err, fifo_level
  );

endinterface

// File: rtl/mult_operand_sequencer_sync_fifo.sv
// Small synchronous FIFO with a combinational head and a separate level counter.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against the registered occupancy.
  always_comb begin
    push_ok_s = push && (level_r != DEPTH_L);
    pop_ok_s  = pop && (level_r != {LW{1'b0}});
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == DEPTH_L);
  assign empty = (level_r == {LW{1'b0}});

endmodule

// File: rtl/mult_operand_sequencer.sv
// Operand sequencer in front of the shift-add multiplier: queues operand
// pairs, issues one multiply at a time, bypasses zero operands and turns a
// multiplier that never finishes into an error-flagged zero result.
module mult_operand_sequencer
  import mult_pkg::*;
#(
  parameter int N       = MULT_N,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = N + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mult_operand_sequencer_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t             state_r;
  logic               mul_start_r;
  logic [N-1:0]       mul_multiplicand_r;
  logic [N-1:0]       mul_multiplier_r;
  logic               out_valid_r;
  logic [2*N-1:0]     out_product_r;
  logic               out_err_r;
  logic [CW-1:0]      wait_cnt_r;

  logic               push_s;
  logic               pop_s;
  logic               in_ready_s;
  logic [2*N-1:0]     head_s;
  logic [N-1:0]       head_a_s;
  logic [N-1:0]       head_b_s;
  logic               head_zero_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_level_s;

  sync_fifo #(
    .WIDTH (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({bus.in_a, bus.in_b}),
    .rdata (head_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Handshake decode: readiness comes only from the registered level, and the
  // FIFO is drained only while the FSM is idle.
  always_comb begin
    in_ready_s  = !fifo_full_s;
    push_s      = bus.in_valid && in_ready_s;
    head_a_s    = head_s[2*N-1:N];
    head_b_s    = head_s[N-1:0];
    head_zero_s = (head_a_s == {N{1'b0}}) || (head_b_s == {N{1'b0}});
    if ((state_r == IDLE) && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Control FSM with all outward-facing signals registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      mul_start_r        <= 1'b0;
      mul_multiplicand_r <= {N{1'b0}};
      mul_multiplier_r   <= {N{1'b0}};
      out_valid_r        <= 1'b0;
      out_product_r      <= {(2*N){1'b0}};
      out_err_r          <= 1'b0;
      wait_cnt_r         <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            mul_multiplicand_r <= head_a_s;
            mul_multiplier_r   <= head_b_s;
            if (head_zero_s) begin
              out_product_r <= {(2*N){1'b0}};
              out_err_r     <= 1'b0;
              out_valid_r   <= 1'b1;
              state_r       <= OUT;
            end else begin
              mul_start_r <= 1'b1;
              state_r     <= START;
            end
          end
        end
        START: begin
          mul_start_r <= 1'b0;
          wait_cnt_r  <= {CW{1'b0}};
          state_r     <= WAIT;
        end
        WAIT: begin
          // done is only trusted here; the multiplier drops it on the start edge.
          if (bus.mul_done) begin
            out_product_r <= bus.mul_product;
            out_err_r     <= 1'b0;
            out_valid_r   <= 1'b1;
            state_r       <= OUT;
          end else if (wait_cnt_r == WAIT_LAST) begin
            out_product_r <= {(2*N){1'b0}};
            out_err_r     <= 1'b1;
            out_valid_r   <= 1'b1;
            state_r       <= OUT;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          mul_start_r <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready         = in_ready_s;
  assign bus.mul_start        = mul_start_r;
  assign bus.mul_multiplicand = mul_multiplicand_r;
  assign bus.mul_multiplier   = mul_multiplier_r;
  assign bus.out_valid        = out_valid_r;
  assign bus.out_product      = out_product_r;
  assign bus.out_err          = out_err_r;
  assign bus.fifo_level       = fifo_level_s;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural shift-add
// multiplier stand-in (done N edges after it samples the start pulse).
module tb_mult_operand_sequencer;
  import mult_pkg::*;

  localparam int N       = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = N + 4;

  logic clk;
  logic rst_n;

  mult_operand_sequencer_if #(.N(N), .DEPTH(DEPTH)) bus ();

  mult_operand_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Multiplier model controls.
  logic no_done   = 1'b0;
  logic stale_req = 1'b0;
  logic busy;
  int   mcnt;

  // Behavioural multiplier: clears done on the start edge, raises it N edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= 1'b0;
      mcnt            <= 0;
      bus.mul_done    <= 1'b0;
      bus.mul_product <= '0;
    end else if (bus.mul_start) begin
      busy            <= 1'b1;
      mcnt            <= 0;
      bus.mul_done    <= 1'b0;
      bus.mul_product <= {{N{1'b0}}, bus.mul_multiplicand} * {{N{1'b0}}, bus.mul_multiplier};
    end else if (busy) begin
      mcnt <= mcnt + 1;
      if ((mcnt + 1 == N) && !no_done) begin
        bus.mul_done <= 1'b1;
        busy         <= 1'b0;
      end
    end else if (stale_req) begin
      bus.mul_done <= 1'b1;
    end
  end

  // Monotonic event counters; tests take deltas.
  int starts  = 0;
  int results = 0;
  always @(posedge clk) begin
    if (bus.mul_start) starts <= starts + 1;
    if (bus.out_valid && bus.out_ready) results <= results + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    int k = 0;
    while (!bus.in_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (!bus.in_ready) check("push_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic collect(input string name, input logic [2*N-1:0] prod, input logic err);
    int lat;
    wait_valid(lat);
    check({name, "_product"}, 32'(bus.out_product), 32'(prod));
    check({name, "_err"}, 32'(bus.out_err), 32'(err));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   32'(bus.in_ready), 32'd1);
    check({tag, "_mul_start"},  32'(bus.mul_start), 32'd0);
    check({tag, "_mcand"},      32'(bus.mul_multiplicand), 32'd0);
    check({tag, "_mplier"},     32'(bus.mul_multiplier), 32'd0);
    check({tag, "_out_valid"},  32'(bus.out_valid), 32'd0);
    check({tag, "_out_prod"},   32'(bus.out_product), 32'd0);
    check({tag, "_out_err"},    32'(bus.out_err), 32'd0);
    check({tag, "_level"},      32'(bus.fifo_level), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] prod;
    int             nstart;
    int             lat;    // 0: latency not checked (zero bypass)
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat;
    int s0;
    int r0;
    int seen;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,   nstart: 1, lat: N + 3};
    vecs[1] = '{a: 8'd0,   b: 8'd200, prod: 16'd0,     nstart: 0, lat: 0};
    vecs[2] = '{a: 8'd255, b: 8'd0,   prod: 16'd0,     nstart: 0, lat: 0};
    vecs[3] = '{a: 8'd255, b: 8'd255, prod: 16'd65025, nstart: 1, lat: N + 3};
    vecs[4] = '{a: 8'd128, b: 8'd2,   prod: 16'd256,   nstart: 1, lat: N + 3};
    vecs[5] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1,     nstart: 1, lat: N + 3};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      s0 = starts;
      push(vecs[i].a, vecs[i].b);
      wait_valid(lat);
      if (vecs[i].lat != 0) check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_starts", i), 32'(starts - s0), 32'(vecs[i].nstart));
      collect($sformatf("vec%0d", i), vecs[i].prod, 1'b0);
      @(posedge clk); #1;
    end

    // Back-pressure: five pairs fill the queue behind the first (stuck in OUT).
    for (int i = 1; i <= 5; i++) push(8'(i), 8'd3);
    check("bp_level_full", 32'(bus.fifo_level), 32'd4);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    bus.in_a = 8'd6;
    bus.in_b = 8'd3;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_sixth_blocked", 32'(bus.fifo_level), 32'd4);
    fork
      begin
        int k = 0;
        while (!bus.in_ready && k < 200) begin
          @(posedge clk); #1; k++;
        end
        check("bp_sixth_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
      begin
        for (int i = 1; i <= 6; i++) collect($sformatf("bp%0d", i), 16'(i * 3), 1'b0);
      end
    join
    @(posedge clk); #1;

    // Multiplier that never completes: error result after TIMEOUT WAIT cycles.
    no_done = 1'b1;
    push(8'd3, 8'd5);
    wait_valid(lat);
    check("to_latency", 32'(lat), 32'(TIMEOUT + 2));
    collect("to", 16'd0, 1'b1);
    no_done = 1'b0;
    push(8'd2, 8'd2);
    collect("after_to", 16'd4, 1'b0);
    @(posedge clk); #1;

    // Stale done level held before START must not short-cut WAIT.
    stale_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("stale_done_high", 32'(bus.mul_done), 32'd1);
    s0 = starts;
    r0 = results;
    push(8'd7, 8'd9);
    wait_valid(lat);
    check("stale_latency", 32'(lat), 32'(N + 3));
    collect("stale", 16'd63, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("stale_one_result", 32'(results - r0), 32'd1);
    check("stale_one_start", 32'(starts - s0), 32'd1);
    check("stale_no_extra_valid", 32'(bus.out_valid), 32'd0);
    stale_req = 1'b0;

    // Reset mid-WAIT with three pairs queued.
    push(8'd9, 8'd9);
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pre_level", 32'(bus.fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.mul_start || (bus.fifo_level != '0)) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    push(8'd4, 8'd4);
    collect("post_rst", 16'd16, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
